// File: rtl/clk_div_ctrl.sv
// Programmable clock divider with start/stop sequencing and a
// glitch-free config handshake applied on half-period boundaries.
module clk_div_ctrl #(
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 2_500_000
) (
  input  logic             clk,
  input  logic             rst_a,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_div,
  output logic             tick,
  output logic             running
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic [CNT_W-1:0] div_reg, div_n;
  logic [CNT_W-1:0] pend_div, pend_div_n;
  logic             pend_valid, pend_valid_n;
  logic             clk_div_n;
  logic             tick_n;
  logic             err_n;
  logic             tc;
  logic             xfer;

  assign tc   = (state != IDLE) &&
                (count == div_reg - 1'b1);
  assign xfer = cfg_valid && cfg_ready;

  always_comb begin
    state_n      = state;
    count_n      = count;
    div_n        = div_reg;
    pend_div_n   = pend_div;
    pend_valid_n = pend_valid;
    clk_div_n    = clk_div;
    tick_n       = 1'b0;
    err_n        = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) state_n = RUN;
      end
      RUN: begin
        if (stop) state_n = STOPPING;
      end
      STOPPING: begin
        if (start && !stop)
          state_n = RUN;
        else if (tc && clk_div)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (state == IDLE) begin
      count_n   = '0;
      clk_div_n = 1'b0;
    end else if (tc) begin
      count_n   = '0;
      clk_div_n = ~clk_div;
      tick_n    = 1'b1;
    end else begin
      count_n = count + 1'b1;
    end

    // Idle has count=0, so a leftover pending value is safe to apply.
    if (pend_valid && (tc || state == IDLE)) begin
      div_n        = pend_div;
      pend_valid_n = 1'b0;
    end

    if (xfer) begin
      if (cfg_div == '0) begin
        err_n = 1'b1;
      end else if (state == IDLE) begin
        div_n = cfg_div;
      end else begin
        pend_div_n   = cfg_div;
        pend_valid_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state      <= IDLE;
      count      <= '0;
      div_reg    <= CNT_W'(DEFAULT_DIV);
      pend_div   <= '0;
      pend_valid <= 1'b0;
      clk_div    <= 1'b0;
      tick       <= 1'b0;
      running    <= 1'b0;
      cfg_ready  <= 1'b1;
      cfg_err    <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      div_reg    <= div_n;
      pend_div   <= pend_div_n;
      pend_valid <= pend_valid_n;
      clk_div    <= clk_div_n;
      tick       <= tick_n;
      running    <= (state_n != IDLE);
      cfg_ready  <= !pend_valid_n;
      cfg_err    <= err_n;
    end
  end

endmodule
